serial_frame_tx: RTL and testbench

Parametrised serial frame transmitter: the next generation of the two-line link transmitter. Frames a DATA_W-bit parallel word as a start bit, MSB-first data and an optional parity bit. It drives the forwarded clock/data pair toward the serial receiver. Adds edge-qualified Send, a one-deep holding buffer for back-to-back frames, a configurable inter-frame gap, and explicit Busy/Accept/Overrun status.

---
 rtl/serial_frame_tx_pkg.sv | 34 +++
 rtl/serial_frame_tx_if.sv | 35 +++
 rtl/serial_frame_tx_send_edge_detect.sv | 29 ++
 rtl/serial_frame_tx.sv | 181 ++++++++++++++++++
 tb/tb_serial_frame_tx.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_frame_tx_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
// Shared types and helpers for the serial frame transmitter.
//   state_t   : transmitter FSM states (idle, shifting a frame, inter-frame gap)
//   par()     : parity bit of a word, zero-extended to PAR_MAX_W bits
//               (zero-extension does not change the XOR reduction)
//   frame_len : number of SDout cycles in one frame (start + data + parity)
//   max_int   : elaboration-time max, used for counter sizing
// ---------------------------------------------------------------------------
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Widest data word the parity helper accepts.
  localparam int PAR_MAX_W = 64;

  // odd = 0: even parity (bit = ^data); odd = 1: bit = ~^data.
  function automatic logic par(input logic [PAR_MAX_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  function automatic int frame_len(input int data_w, input int p);
    return 1 + data_w + p;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// ---------------------------------------------------------------------------
// serial_frame_tx_if
// Request and serial-link signals of the serial frame transmitter.
//   Send    : request, rising edge starts or queues a frame (master -> slave)
//   PDin    : DATA_W-bit parallel word                          (master -> slave)
//   SCout   : forwarded clock                                   (slave -> master)
//   SDout   : registered serial data, idle 0                    (slave -> master)
//   Busy    : frame or gap in progress                          (slave -> master)
//   Accept  : one-cycle pulse, request captured                 (slave -> master)
//   Overrun : one-cycle pulse, request dropped, hold full       (slave -> master)
// The slave modport is the transmitter side.
// ---------------------------------------------------------------------------
interface serial_frame_tx_if #(
  parameter int DATA_W = 8
);

  logic              Send;
  logic [DATA_W-1:0] PDin;
  logic              SCout;
  logic              SDout;
  logic              Busy;
  logic              Accept;
  logic              Overrun;

  modport master (
    output Send, PDin,
    input  SCout, SDout, Busy, Accept, Overrun
  );

  modport slave (
    input  Send, PDin,
    output SCout, SDout, Busy, Accept, Overrun
  );

endinterface

// File: rtl/serial_frame_tx_send_edge_detect.sv
// ---------------------------------------------------------------------------
// send_edge_detect
// Registers Send and produces a one-cycle req on a 0->1 transition.
//   Clk  : clock
//   Rst  : synchronous active-high reset
//   Send : raw request level
//   req  : Send & ~Send_q
// Send_q resets to 1 so a Send held high through reset does not fire.
// ---------------------------------------------------------------------------
module send_edge_detect (
  input  logic Clk,
  input  logic Rst,
  input  logic Send,
  output logic req
);

  logic send_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      send_q <= 1'b1;
    end else begin
      send_q <= Send;
    end
  end

  assign req = Send & ~send_q;

endmodule

// File: rtl/serial_frame_tx.sv
// ---------------------------------------------------------------------------
// serial_frame_tx
// Serial frame transmitter: start bit (1), DATA_W data bits MSB first and an
// optional parity bit, followed by GAP forced-zero cycles. A one-deep hold
// buffer allows back-to-back frames.
// Parameters:
//   DATA_W     : data bits per frame (1..64)
//   GAP        : idle cycles forced after each frame
//   ODD_PARITY : 0 even parity, 1 odd parity (only used with parity enabled)
// Ports:
//   Clk : clock, all logic on posedge
//   Rst : synchronous active-high reset
//   bus : serial_frame_tx_if.slave (Send, PDin, SCout, SDout, Busy,
//         Accept, Overrun)
// Configuration macro:
//   SERIAL_TX_PARITY_EN : when defined a parity bit is appended to each frame.
// ---------------------------------------------------------------------------
module serial_frame_tx
  import serial_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int GAP        = 0,
  parameter bit ODD_PARITY = 1'b0
) (
  input logic              Clk,
  input logic              Rst,
  serial_frame_tx_if.slave bus
);

`ifdef SERIAL_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  // The shift register always has room for the parity slot; without parity
  // the counter simply stops before that slot is shifted out.
  localparam int SH_W  = DATA_W + 1;
  localparam int CNT_W = $clog2(max_int(DATA_W + P + 1, GAP + 1));
  localparam logic [CNT_W-1:0] BITS_LOAD = CNT_W'(frame_len(DATA_W, P) - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(max_int(GAP - 1, 0));
  localparam bit HAS_GAP = (GAP > 0);

  state_t            state;
  state_t            next_state;
  logic              req;
  logic [SH_W-1:0]   sh;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] hold;
  logic              hold_valid;
  logic              sd_out;
  logic              accept;
  logic              overrun;

  logic              frame_end;
  logic              to_gap;
  logic              start_frame;
  logic              use_hold;
  logic              capture_hold;
  logic              hold_valid_next;
  logic              accept_next;
  logic              overrun_next;
  logic [DATA_W-1:0] start_word;
  logic [SH_W-1:0]   frame_bits;

  send_edge_detect u_edge (
    .Clk  (Clk),
    .Rst  (Rst),
    .Send (bus.Send),
    .req  (req)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (start_frame) next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (to_gap)         next_state = ST_GAP;
        else if (frame_end) next_state = start_frame ? ST_SHIFT : ST_IDLE;
      end
      ST_GAP: begin
        if (frame_end) next_state = start_frame ? ST_SHIFT : ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Output/control decode. At frame-end a held word has priority over a new
  // request; the request then refills the hold that was just freed.
  always_comb begin
    frame_end       = 1'b0;
    to_gap          = 1'b0;
    start_frame     = 1'b0;
    use_hold        = 1'b0;
    capture_hold    = 1'b0;
    accept_next     = 1'b0;
    overrun_next    = 1'b0;
    hold_valid_next = hold_valid;

    if (state == ST_SHIFT && cnt == '0) begin
      if (HAS_GAP) to_gap    = 1'b1;
      else         frame_end = 1'b1;
    end
    if (state == ST_GAP && cnt == '0) frame_end = 1'b1;

    if (state == ST_IDLE) begin
      start_frame = req;
      accept_next = req;
    end else if (frame_end) begin
      start_frame  = hold_valid | req;
      use_hold     = hold_valid;
      capture_hold = hold_valid & req;
      accept_next  = req;
    end else if (req) begin
      capture_hold = ~hold_valid;
      accept_next  = ~hold_valid;
      overrun_next = hold_valid;
    end

    if (capture_hold)  hold_valid_next = 1'b1;
    else if (use_hold) hold_valid_next = 1'b0;

    start_word = use_hold ? hold : bus.PDin;
    frame_bits = {start_word, par(PAR_MAX_W'(start_word), ODD_PARITY)};
  end

  // Datapath: shift register, shared bit/gap counter, hold buffer, pulses.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sh         <= '0;
      cnt        <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      sd_out     <= 1'b0;
      accept     <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      accept     <= accept_next;
      overrun    <= overrun_next;
      hold_valid <= hold_valid_next;
      if (capture_hold) hold <= bus.PDin;

      if (start_frame) begin
        sd_out <= 1'b1;
        sh     <= frame_bits;
        cnt    <= BITS_LOAD;
      end else if (state == ST_SHIFT && cnt != '0) begin
        sd_out <= sh[SH_W-1];
        sh     <= {sh[SH_W-2:0], 1'b0};
        cnt    <= cnt - 1'b1;
      end else if (to_gap) begin
        sd_out <= 1'b0;
        cnt    <= GAP_LOAD;
      end else if (state == ST_GAP && cnt != '0) begin
        sd_out <= 1'b0;
        cnt    <= cnt - 1'b1;
      end else begin
        sd_out <= 1'b0;
      end
    end
  end

  assign bus.SCout   = Clk;
  assign bus.SDout   = sd_out;
  assign bus.Busy    = (state != ST_IDLE);
  assign bus.Accept  = accept;
  assign bus.Overrun = overrun;

endmodule

// File: tb/tb_serial_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_frame_tx
// Self-checking bench for serial_frame_tx. Two instances share Clk/Rst:
//   dutA : DATA_W=8, GAP=0, even parity
//   dutB : DATA_W=8, GAP=2, odd parity
// Expected per-cycle {SDout, Busy, Accept, Overrun} values are queued when
// stimulus is driven and popped each cycle. Honours SERIAL_TX_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_serial_frame_tx;

`ifdef SERIAL_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int DW   = 8;
  localparam int FLEN = 1 + DW + P;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  serial_frame_tx_if #(.DATA_W(DW)) busA ();
  serial_frame_tx_if #(.DATA_W(DW)) busB ();

  serial_frame_tx #(.DATA_W(DW), .GAP(0), .ODD_PARITY(1'b0)) dutA (
    .Clk (Clk),
    .Rst (Rst),
    .bus (busA)
  );

  serial_frame_tx #(.DATA_W(DW), .GAP(2), .ODD_PARITY(1'b1)) dutB (
    .Clk (Clk),
    .Rst (Rst),
    .bus (busB)
  );

  int nVec = 0;
  int nMis = 0;
  logic [3:0] expQ[$];

  // Drive both instances for one clock; returns just after the next negedge.
  task automatic tick(input logic sendA, input logic [DW-1:0] pdA,
                      input logic sendB, input logic [DW-1:0] pdB);
    busA.Send = sendA;
    busA.PDin = pdA;
    busB.Send = sendB;
    busB.PDin = pdB;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  function automatic logic parBit(input logic [DW-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  // Queue the cycles of one frame plus gapN busy zero cycles.
  function automatic void pushFrame(input logic [DW-1:0] d, input logic odd,
                                    input int gapN, input logic acc);
    expQ.push_back({1'b1, 1'b1, acc, 1'b0});
    for (int i = DW - 1; i >= 0; i--) expQ.push_back({d[i], 1'b1, 1'b0, 1'b0});
    if (P == 1) expQ.push_back({parBit(d, odd), 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < gapN; i++) expQ.push_back(4'b0100);
  endfunction

  function automatic void padIdle(input int n);
    while (expQ.size() < n) expQ.push_back(4'b0000);
  endfunction

  task automatic test_reset();
    logic [3:0] obs;
    Rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) Rst = 1'b0;
      tick(1'b1, 8'hFF, 1'b1, 8'hFF);
      obs = {busA.SDout, busA.Busy, busA.Accept, busA.Overrun};
      nVec++;
      if (obs !== 4'b0000) begin
        nMis++;
        $display("[TB] FAIL reset_A cycle %0d: got %b expected 0000", i, obs);
      end
      obs = {busB.SDout, busB.Busy, busB.Accept, busB.Overrun};
      nVec++;
      if (obs !== 4'b0000) begin
        nMis++;
        $display("[TB] FAIL reset_B cycle %0d: got %b expected 0000", i, obs);
      end
    end
    tick(1'b0, '0, 1'b0, '0);
    tick(1'b0, '0, 1'b0, '0);
    @(posedge Clk);
    #1;
    nVec++;
    if (busA.SCout !== 1'b1) begin
      nMis++;
      $display("[TB] FAIL scout_high: got %b expected 1", busA.SCout);
    end
    @(negedge Clk);
    nVec++;
    if (busA.SCout !== 1'b0) begin
      nMis++;
      $display("[TB] FAIL scout_low: got %b expected 0", busA.SCout);
    end
  endtask

  task automatic test_frame_a5();
    logic [3:0] obs, exp;
    expQ.delete();
    pushFrame(8'hA5, 1'b0, 0, 1'b1);
    padIdle(FLEN + 3);
    for (int i = 0; i < FLEN + 3; i++) begin
      tick(i == 0, 8'hA5, 1'b0, '0);
      obs = {busA.SDout, busA.Busy, busA.Accept, busA.Overrun};
      exp = expQ.pop_front();
      nVec++;
      if (obs !== exp) begin
        nMis++;
        $display("[TB] FAIL frame_a5 cycle %0d: got %b expected %b (SDout,Busy,Accept,Overrun)", i, obs, exp);
      end
    end
  endtask

  task automatic test_parity();
    logic [3:0] obs, exp;
    for (int s = 0; s < 2; s++) begin
      expQ.delete();
      pushFrame(8'h07, s == 1, (s == 1) ? 2 : 0, 1'b1);
      padIdle(FLEN + 5);
      for (int i = 0; i < FLEN + 5; i++) begin
        tick(s == 0 && i == 0, 8'h07, s == 1 && i == 0, 8'h07);
        if (s == 0) obs = {busA.SDout, busA.Busy, busA.Accept, busA.Overrun};
        else        obs = {busB.SDout, busB.Busy, busB.Accept, busB.Overrun};
        exp = expQ.pop_front();
        nVec++;
        if (obs !== exp) begin
          nMis++;
          $display("[TB] FAIL parity_%s cycle %0d: got %b expected %b (SDout,Busy,Accept,Overrun)",
                   (s == 0) ? "even" : "odd", i, obs, exp);
        end
      end
    end
  endtask

  task automatic test_send_held();
    logic [3:0] obs, exp;
    expQ.delete();
    pushFrame(8'h3C, 1'b0, 0, 1'b1);
    padIdle(34);
    for (int i = 0; i < 34; i++) begin
      tick(i < 30, 8'h3C, 1'b0, '0);
      obs = {busA.SDout, busA.Busy, busA.Accept, busA.Overrun};
      exp = expQ.pop_front();
      nVec++;
      if (obs !== exp) begin
        nMis++;
        $display("[TB] FAIL send_held cycle %0d: got %b expected %b (SDout,Busy,Accept,Overrun)", i, obs, exp);
      end
    end
  endtask

  // Gap instance: second request goes to hold, third overruns and is lost.
  task automatic test_gap_overrun();
    logic [3:0] obs, exp;
    logic [DW-1:0] pd;
    int n;
    expQ.delete();
    pushFrame(8'h3C, 1'b1, 2, 1'b1);
    pushFrame(8'h5A, 1'b1, 2, 1'b0);
    expQ[3] = expQ[3] | 4'b0010;
    expQ[6] = expQ[6] | 4'b0001;
    n = 2 * (FLEN + 2) + 4;
    padIdle(n);
    for (int i = 0; i < n; i++) begin
      pd = (i < 3) ? 8'h3C : (i < 6) ? 8'h5A : 8'hFF;
      tick(1'b0, '0, i == 0 || i == 3 || i == 6, pd);
      obs = {busB.SDout, busB.Busy, busB.Accept, busB.Overrun};
      exp = expQ.pop_front();
      nVec++;
      if (obs !== exp) begin
        nMis++;
        $display("[TB] FAIL gap_overrun cycle %0d: got %b expected %b (SDout,Busy,Accept,Overrun)", i, obs, exp);
      end
    end
  endtask

  // Frame-end with hold full plus new request, then frame-end with hold
  // empty plus new request: both must chain with no idle cycle.
  task automatic test_back_to_back();
    logic [3:0] obs, exp;
    logic [DW-1:0] pd;
    int n;
    expQ.delete();
    pushFrame(8'hC1, 1'b0, 0, 1'b1);
    pushFrame(8'h96, 1'b0, 0, 1'b1);
    pushFrame(8'h3E, 1'b0, 0, 1'b0);
    pushFrame(8'h4B, 1'b0, 0, 1'b1);
    expQ[3] = expQ[3] | 4'b0010;
    n = 4 * FLEN + 3;
    padIdle(n);
    for (int i = 0; i < n; i++) begin
      pd = (i < 3) ? 8'hC1 : (i < FLEN) ? 8'h96 : (i < 3 * FLEN) ? 8'h3E : 8'h4B;
      tick(i == 0 || i == 3 || i == FLEN || i == 3 * FLEN, pd, 1'b0, '0);
      obs = {busA.SDout, busA.Busy, busA.Accept, busA.Overrun};
      exp = expQ.pop_front();
      nVec++;
      if (obs !== exp) begin
        nMis++;
        $display("[TB] FAIL back_to_back cycle %0d: got %b expected %b (SDout,Busy,Accept,Overrun)", i, obs, exp);
      end
    end
  endtask

  // Reset mid-frame with a word waiting in hold; the held word must never
  // appear and the next request gives a complete fresh frame.
  task automatic test_reset_mid_frame();
    logic [3:0] obs, exp;
    logic [DW-1:0] pd;
    logic [DW-1:0] cw;
    int n;
    cw = 8'hC3;
    expQ.delete();
    expQ.push_back(4'b1110);
    expQ.push_back({cw[7], 3'b100});
    expQ.push_back({cw[6], 3'b110});
    expQ.push_back({cw[5], 3'b100});
    expQ.push_back(4'b0000);
    expQ.push_back(4'b0000);
    pushFrame(8'h81, 1'b0, 0, 1'b1);
    n = 6 + 2 * FLEN + 2;
    padIdle(n);
    for (int i = 0; i < n; i++) begin
      Rst = (i == 4);
      pd = (i < 2) ? 8'hC3 : (i < 6) ? 8'h99 : 8'h81;
      tick(i == 0 || (i >= 2 && i <= 3) || i == 6, pd, 1'b0, '0);
      obs = {busA.SDout, busA.Busy, busA.Accept, busA.Overrun};
      exp = expQ.pop_front();
      nVec++;
      if (obs !== exp) begin
        nMis++;
        $display("[TB] FAIL reset_mid_frame cycle %0d: got %b expected %b (SDout,Busy,Accept,Overrun)", i, obs, exp);
      end
    end
    Rst = 1'b0;
  endtask

  initial begin
    busA.Send = 1'b0;
    busA.PDin = '0;
    busB.Send = 1'b0;
    busB.PDin = '0;
    test_reset();
    test_frame_a5();
    test_parity();
    test_send_held();
    test_gap_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
